// File: rtl/zest_spi_sched_if.sv
// Zest SPI scheduler bus bundle: requester side plus SPI engine side.
// slave is the scheduler's view; master is the view of the logic driving it.
interface zest_spi_sched_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = 32
) ();

  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_word;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      rdata;
  logic               err;
  logic [GW-1:0]      grant_id;
  logic               active;
  logic               spi_start;
  logic [DW-1:0]      spi_word;
  logic               spi_busy;
  logic               spi_done;
  logic [DW-1:0]      spi_rdata;
  logic [7:0]         timeout_cnt;

  modport slave (
    input  req, req_word, spi_busy, spi_done, spi_rdata,
    output ack, rdata, err, grant_id, active, spi_start, spi_word, timeout_cnt
  );

  modport master (
    output req, req_word, spi_busy, spi_done, spi_rdata,
    input  ack, rdata, err, grant_id, active, spi_start, spi_word, timeout_cnt
  );

endinterface

// File: rtl/zest_spi_sched.sv
// Round-robin scheduler sharing one Zest SPI engine among NREQ requesters.
// Each transfer: grant, one-cycle start, wait for done or timeout, ack, gap.
module zest_spi_sched #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned GAP     = 4
) (
  input  logic             lb_clk,
  input  logic             rst_n,
  zest_spi_sched_if.slave  bus
);

  localparam int unsigned GW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WCW = $clog2(TIMEOUT);
  localparam int unsigned GCW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE,
    S_GAP
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [GW-1:0]   ptr_q;
  logic [GW-1:0]   grant_q;
  logic [DW-1:0]   word_q;
  logic [WCW-1:0]  wait_q;
  logic [GCW-1:0]  gap_q;
  logic [NREQ-1:0] ack_q;
  logic [DW-1:0]   rdata_q;
  logic            err_q;
  logic            start_q;
  logic            active_q;
  logic [7:0]      tcnt_q;

  logic [GW-1:0]   pick;
  logic            pick_vld;
  logic            grant_en;
  logic            done_hit;
  logic            to_hit;

  // First requester at or after the round-robin pointer, circularly.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % int'(NREQ);
      if (!pick_vld && bus.req[idx]) begin
        pick_vld = 1'b1;
        pick     = GW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge lb_clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and per-cycle strobes for the datapath.
  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    done_hit = 1'b0;
    to_hit   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld && !bus.spi_busy) begin
          grant_en = 1'b1;
          state_d  = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.spi_done) begin
          done_hit = 1'b1;
          state_d  = S_DONE;
        end else if (wait_q == WCW'(TIMEOUT - 1)) begin
          to_hit  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = (GAP == 0) ? S_IDLE : S_GAP;
      S_GAP: begin
        if ((int'(gap_q) + 1) >= int'(GAP)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: grant capture, counters, registered outputs.
  always_ff @(posedge lb_clk) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      grant_q  <= '0;
      word_q   <= '0;
      wait_q   <= '0;
      gap_q    <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      active_q <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      start_q  <= (state_d == S_START);
      active_q <= (state_d == S_START) || (state_d == S_WAIT) || (state_d == S_DONE);

      if (grant_en) begin
        grant_q <= pick;
        word_q  <= bus.req_word[int'(pick)*int'(DW) +: DW];
      end

      if (state_q == S_START) begin
        wait_q <= '0;
      end else if (state_q == S_WAIT) begin
        wait_q <= wait_q + WCW'(1);
      end

      if (state_q == S_DONE) begin
        gap_q <= '0;
      end else if (state_q == S_GAP) begin
        gap_q <= gap_q + GCW'(1);
      end

      // ack/rdata/err live for exactly the DONE cycle.
      ack_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      if (done_hit || to_hit) begin
        for (int i = 0; i < int'(NREQ); i++) begin
          ack_q[i] <= (GW'(i) == grant_q);
        end
      end
      if (done_hit) begin
        rdata_q <= bus.spi_rdata;
      end
      if (to_hit) begin
        err_q <= 1'b1;
        if (tcnt_q != 8'hFF) begin
          tcnt_q <= tcnt_q + 8'd1;
        end
      end

      if (state_q == S_DONE) begin
        ptr_q <= (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);
      end
    end
  end

  assign bus.ack         = ack_q;
  assign bus.rdata       = rdata_q;
  assign bus.err         = err_q;
  assign bus.grant_id    = grant_q;
  assign bus.active      = active_q;
  assign bus.spi_start   = start_q;
  assign bus.spi_word    = word_q;
  assign bus.timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_zest_spi_sched.sv
// Self-checking bench for zest_spi_sched: directed vector table, corner-case
// sequences, and a randomized run against a cycle-count reference model.
module tb_zest_spi_sched;

  localparam int unsigned NREQ    = 3;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned GAP     = 4;

  logic lb_clk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 lb_clk = ~lb_clk;

  zest_spi_sched_if #(.NREQ(NREQ), .DW(DW)) bus ();

  zest_spi_sched #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .lb_clk (lb_clk),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  int cyc = 0;
  always @(posedge lb_clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Simple engine emulation and transaction monitor state
  bit          auto_eng  = 1'b1;
  bit          auto_drop = 1'b1;
  bit          hold_all  = 1'b0;
  int          eng_delay = 0;
  logic [31:0] eng_rdata = '0;
  bit          eng_pend  = 1'b0;
  int          eng_due   = 0;
  logic [2:0]  rearm     = '0;
  int          n_start   = 0;
  int          n_ack     = 0;
  int          start_cyc = 0;
  int          ack_cyc   = 0;
  logic [2:0]  ack_mask  = '0;
  logic [31:0] ack_rdata = '0;
  logic        ack_err   = 1'b0;
  int          glog[$];
  int          slog[$];

  typedef struct {
    logic [2:0]  req;
    int          delay;   // cycles from spi_start to spi_done; 0 = engine silent
    logic [31:0] rd;
    int          gnt;
    logic [2:0]  ack;
    logic [31:0] erd;
    logic        err;
    int          lat;     // ack cycle minus spi_start cycle
  } vec_t;

  vec_t tbl[7];

  function automatic logic [31:0] wd(input int row, input int i);
    return 32'hA5A50001 + 32'(row * 256 + i * 16);
  endfunction

  function automatic logic [79:0] snap();
    return {bus.ack, bus.rdata, bus.err, bus.grant_id, bus.active,
            bus.spi_start, bus.spi_word, bus.timeout_cnt};
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [31:0] w);
    bus.req_word[i*DW +: DW] = w;
  endtask

  // One clock: sample point #1 after the edge, then engine and monitor updates.
  task automatic step();
    @(posedge lb_clk);
    #1;
    if (auto_eng) begin
      bus.spi_done = 1'b0;
      if (eng_pend && cyc == eng_due) begin
        bus.spi_done  = 1'b1;
        bus.spi_rdata = eng_rdata;
        eng_pend      = 1'b0;
      end
      if (bus.spi_start && eng_delay != 0) begin
        eng_pend = 1'b1;
        eng_due  = cyc + eng_delay;
      end
    end
    if (bus.spi_start) begin
      n_start++;
      glog.push_back(int'(bus.grant_id));
      slog.push_back(cyc);
      start_cyc = cyc;
    end
    if (bus.ack != '0) begin
      n_ack++;
      ack_cyc   = cyc;
      ack_mask  = bus.ack;
      ack_rdata = bus.rdata;
      ack_err   = bus.err;
      if (auto_drop) begin
        bus.req = bus.req & ~bus.ack;
        if (hold_all) rearm = bus.ack;
      end
    end else if (rearm != '0) begin
      bus.req = bus.req | rearm;
      rearm   = '0;
    end
  endtask

  task automatic do_reset();
    bus.req      = '0;
    bus.spi_busy = 1'b0;
    bus.spi_done = 1'b0;
    eng_pend     = 1'b0;
    rearm        = '0;
    rst_n        = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input int target, input int budget, input string nm);
    int k = 0;
    while (n_ack < target && k < budget) begin
      step();
      k++;
    end
    chk(nm, 80'(n_ack), 80'(target));
  endtask

  task automatic wait_start(input int target, input int budget, input string nm);
    int k = 0;
    while (n_start < target && k < budget) begin
      step();
      k++;
    end
    chk(nm, 80'(n_start), 80'(target));
  endtask

  // Reference model: transfers tracked as cycle numbers derived from the
  // documented latencies; round-robin pick done on the request vector.
  task automatic random_phase();
    int          ptr, idle_from, m_start, m_done, m_ack, m_grant, d;
    bit          inf;
    logic [31:0] m_word, m_rdata;
    logic        m_err;
    logic [7:0]  tc;
    logic [31:0] words[3];
    logic [2:0]  e_ack;
    logic [79:0] e;
    bit          found;
    do_reset();
    auto_eng  = 1'b0;
    ptr       = 0;
    inf       = 1'b0;
    idle_from = cyc;
    m_start   = -1;
    m_done    = -1;
    m_ack     = -1;
    m_grant   = 0;
    m_word    = '0;
    m_rdata   = '0;
    m_err     = 1'b0;
    tc        = '0;
    for (int i = 0; i < 3; i++) begin
      words[i] = '0;
      set_word(i, '0);
    end
    for (int n = 0; n < 6000 && bad < 40; n++) begin
      @(posedge lb_clk);
      #1;
      if (inf && cyc == m_ack && m_err && tc != 8'hFF) tc++;
      e_ack = (inf && cyc == m_ack) ? 3'(1 << m_grant) : 3'b000;
      e = {e_ack, (e_ack != '0) ? m_rdata : 32'h0, (e_ack != '0) & m_err,
           2'(m_grant), inf && cyc >= m_start && cyc <= m_ack,
           inf && cyc == m_start, m_word, tc};
      chk("rand_cycle", snap(), e);
      if (e_ack != '0) begin
        inf       = 1'b0;
        ptr       = (m_grant + 1) % 3;
        idle_from = cyc + int'(GAP) + 1;
      end
      for (int i = 0; i < 3; i++) begin
        if (e_ack[i]) begin
          bus.req[i] = 1'b0;
        end else if (!bus.req[i] && $urandom_range(0, 7) == 0) begin
          words[i] = $urandom;
          set_word(i, words[i]);
          bus.req[i] = 1'b1;
        end
      end
      bus.spi_busy  = ($urandom_range(0, 5) == 0);
      bus.spi_rdata = $urandom;
      bus.spi_done  = 1'b0;
      if (inf && cyc == m_done) begin
        bus.spi_done  = 1'b1;
        bus.spi_rdata = m_rdata;
      end else if (!inf && $urandom_range(0, 15) == 0) begin
        bus.spi_done = 1'b1;
      end
      if (!inf && cyc >= idle_from && bus.req != '0 && !bus.spi_busy) begin
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
          if (!found && bus.req[(ptr + k) % 3]) begin
            found   = 1'b1;
            m_grant = (ptr + k) % 3;
          end
        end
        inf     = 1'b1;
        m_start = cyc + 1;
        m_word  = words[m_grant];
        d       = int'($urandom_range(1, 72));
        if (d <= int'(TIMEOUT)) begin
          m_done  = m_start + d;
          m_ack   = m_done + 1;
          m_rdata = $urandom;
          m_err   = 1'b0;
        end else begin
          m_done  = -1;
          m_ack   = m_start + int'(TIMEOUT) + 1;
          m_rdata = '0;
          m_err   = 1'b1;
        end
      end
    end
    auto_eng = 1'b1;
  endtask

  int fair_exp[4] = '{0, 1, 2, 0};
  int skip_exp[3] = '{0, 2, 0};

  initial begin
    bus.req       = '0;
    bus.req_word  = '0;
    bus.spi_busy  = 1'b0;
    bus.spi_done  = 1'b0;
    bus.spi_rdata = '0;

    tbl[0] = '{3'b001, 10, 32'h12345678, 0, 3'b001, 32'h12345678, 1'b0, 11};
    tbl[1] = '{3'b101,  3, 32'hDEADBEEF, 2, 3'b100, 32'hDEADBEEF, 1'b0,  4};
    tbl[2] = '{3'b011, 64, 32'hCAFEF00D, 0, 3'b001, 32'hCAFEF00D, 1'b0, 65};
    tbl[3] = '{3'b011,  0, 32'h0BADF00D, 1, 3'b010, 32'h00000000, 1'b1, 65};
    tbl[4] = '{3'b001,  1, 32'h00000001, 0, 3'b001, 32'h00000001, 1'b0,  2};
    tbl[5] = '{3'b110,  7, 32'h80000000, 1, 3'b010, 32'h80000000, 1'b0,  8};
    tbl[6] = '{3'b010,  2, 32'h5A5A5A5A, 1, 3'b010, 32'h5A5A5A5A, 1'b0,  3};

    do_reset();
    chk("reset_state", snap(), '0);

    // Directed single transfers; pointer advances row to row
    for (int r = 0; r < 7; r++) begin
      bus.req   = '0;
      hold_all  = 1'b0;
      auto_drop = 1'b1;
      repeat (GAP + 2) step();
      for (int i = 0; i < 3; i++) set_word(i, wd(r, i));
      eng_delay = tbl[r].delay;
      eng_rdata = tbl[r].rd;
      n_start   = 0;
      n_ack     = 0;
      bus.req   = tbl[r].req;
      step();
      chk("tbl_start", 80'({bus.spi_start, bus.active, bus.grant_id, bus.spi_word}),
          80'({1'b1, 1'b1, 2'(tbl[r].gnt), wd(r, tbl[r].gnt)}));
      wait_ack(1, 100, "tbl_ack_seen");
      bus.req = '0;
      chk("tbl_ack", 80'({ack_mask, ack_rdata, ack_err}),
          80'({tbl[r].ack, tbl[r].erd, tbl[r].err}));
      chk("tbl_latency", 80'(ack_cyc - start_cyc), 80'(tbl[r].lat));
      step();
      chk("tbl_clear", 80'({bus.ack, bus.rdata, bus.err}), '0);
      chk("tbl_one_start", 80'(n_start), 80'(1));
    end
    chk("tbl_timeout_cnt", 80'(bus.timeout_cnt), 80'(1));

    // All three held: strict rotation with fixed start spacing
    do_reset();
    for (int i = 0; i < 3; i++) set_word(i, wd(9, i));
    eng_delay = 5;
    auto_drop = 1'b1;
    hold_all  = 1'b1;
    glog.delete();
    slog.delete();
    n_start = 0;
    n_ack   = 0;
    bus.req = 3'b111;
    wait_start(4, 200, "fair_starts");
    if (glog.size() >= 4) begin
      for (int k = 0; k < 4; k++) chk("fair_order", 80'(glog[k]), 80'(fair_exp[k]));
      for (int k = 0; k < 3; k++) chk("fair_spacing", 80'(slog[k+1] - slog[k]), 80'(3 + GAP + 5));
    end
    wait_ack(4, 100, "fair_drain");
    hold_all = 1'b0;
    rearm    = '0;
    bus.req  = '0;
    repeat (GAP + 2) step();

    // Continuous req[0], req[2] joins mid-transfer, idle req[1] skipped
    do_reset();
    glog.delete();
    n_start   = 0;
    n_ack     = 0;
    eng_delay = 5;
    auto_drop = 1'b0;
    bus.req   = 3'b001;
    wait_start(1, 20, "skip_first");
    bus.req[2] = 1'b1;
    wait_start(3, 100, "skip_starts");
    if (glog.size() >= 3) begin
      for (int k = 0; k < 3; k++) chk("skip_order", 80'(glog[k]), 80'(skip_exp[k]));
    end
    bus.req = '0;
    wait_ack(3, 100, "skip_drain");
    auto_drop = 1'b1;
    repeat (GAP + 2) step();

    // Silent engine: timeout ack, then saturation of the timeout counter
    do_reset();
    n_start   = 0;
    n_ack     = 0;
    eng_delay = 0;
    hold_all  = 1'b0;
    bus.req   = 3'b001;
    wait_ack(1, 100, "to_ack_seen");
    chk("to_ack", 80'({ack_mask, ack_rdata, ack_err}), 80'({3'b001, 32'h0, 1'b1}));
    chk("to_latency", 80'(ack_cyc - start_cyc), 80'(TIMEOUT + 1));
    chk("to_count_1", 80'(bus.timeout_cnt), 80'(1));
    hold_all = 1'b1;
    bus.req  = 3'b001;
    wait_ack(300, 300 * 80, "to_300_acks");
    chk("to_saturate", 80'(bus.timeout_cnt), 80'(255));
    hold_all = 1'b0;
    rearm    = '0;
    bus.req  = '0;
    repeat (GAP + 2) step();

    // Busy engine blocks grants in IDLE
    do_reset();
    n_start      = 0;
    n_ack        = 0;
    eng_delay    = 3;
    bus.spi_busy = 1'b1;
    bus.req      = 3'b010;
    repeat (20) step();
    chk("busy_hold", 80'(n_start), 80'(0));
    bus.spi_busy = 1'b0;
    step();
    chk("busy_release", 80'({bus.spi_start, bus.grant_id}), 80'({1'b1, 2'd1}));
    wait_ack(1, 50, "busy_ack");
    bus.req = '0;
    repeat (GAP + 2) step();

    // Reset in the middle of WAIT drops the transfer and the pointer
    do_reset();
    n_start   = 0;
    n_ack     = 0;
    eng_delay = 0;
    bus.req   = 3'b001;
    wait_start(1, 10, "rst_first");
    repeat (5) step();
    rst_n = 1'b0;
    step();
    chk("rst_mid_outputs", snap(), '0);
    rst_n   = 1'b1;
    bus.req = '0;
    repeat (80) step();
    chk("rst_no_ack", 80'(n_ack), 80'(0));
    eng_delay = 2;
    bus.req   = 3'b110;
    step();
    chk("rst_ptr_grant", 80'({bus.spi_start, bus.grant_id}), 80'({1'b1, 2'd1}));
    wait_ack(1, 50, "rst_ack");
    bus.req = '0;
    repeat (GAP + 2) step();

    random_phase();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
